// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, valid/ready request issue, in-order response
// capture with stale-response dropping, and a 2-entry {pc, instr} queue to the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;

    logic        pop;
    logic        hs;
    logic        rsp;
    logic        keep;
    logic [2:0]  occupancy;
    logic [1:0]  addr_slot;
    logic [1:0]  count_after_pop;

    assign out_valid     = (count_q != 2'd0);
    assign out_pc        = e0_pc_q;
    assign out_instr     = e0_instr_q;
    assign imem_req_addr = pc_q;

    assign pop       = out_valid & out_ready;
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    // Requests are only issued when the queue is guaranteed room for their response.
    assign imem_req_valid = (state_q == ST_RUN) & ~rst & (occupancy < 3'd2);
    assign hs        = imem_req_valid & imem_req_ready;
    assign rsp       = imem_rsp_valid & (inflight_q != 2'd0);
    assign keep      = rsp & (drop_q == 2'd0) & ~redirect_valid;

    assign addr_slot       = inflight_q - {1'b0, rsp};
    assign count_after_pop = count_q - {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q + {1'b0, hs} - {1'b0, rsp};
        drop_d     = drop_q;
        count_d    = count_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        e0_pc_d    = e0_pc_q;
        e0_instr_d = e0_instr_q;
        e1_pc_d    = e1_pc_q;
        e1_instr_d = e1_instr_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        // Address FIFO tracks every accepted request; head is the oldest outstanding one.
        if (rsp) begin
            addr0_d = addr1_q;
        end else begin
            addr0_d = addr0_q;
        end
        if (hs) begin
            if (addr_slot == 2'd0) begin
                addr0_d = pc_q;
            end else begin
                addr1_d = pc_q;
            end
        end else begin
            addr1_d = addr1_q;
        end

        if (redirect_valid) begin
            pc_d    = redirect_pc & ALIGN_MASK;
            drop_d  = inflight_d;
            count_d = 2'd0;
        end else begin
            if (hs) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            if (rsp && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end else begin
                drop_d = drop_q;
            end
            if (pop) begin
                e0_pc_d    = e1_pc_q;
                e0_instr_d = e1_instr_q;
            end else begin
                e0_pc_d    = e0_pc_q;
                e0_instr_d = e0_instr_q;
            end
            if (keep) begin
                if (count_after_pop == 2'd0) begin
                    e0_pc_d    = addr0_q;
                    e0_instr_d = imem_rsp_data;
                end else begin
                    e1_pc_d    = addr0_q;
                    e1_instr_d = imem_rsp_data;
                end
            end else begin
                e1_pc_d    = e1_pc_q;
                e1_instr_d = e1_instr_q;
            end
            count_d = count_after_pop + {1'b0, keep};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC & ALIGN_MASK;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            count_q    <= 2'd0;
            addr0_q    <= 32'd0;
            addr1_q    <= 32'd0;
            e0_pc_q    <= 32'd0;
            e0_instr_q <= 32'd0;
            e1_pc_q    <= 32'd0;
            e1_instr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            e0_pc_q    <= e0_pc_d;
            e0_instr_q <= e0_instr_d;
            e1_pc_q    <= e1_pc_d;
            e1_instr_q <= e1_instr_d;
        end
    end

endmodule
